// File: rtl/time_set_editor_pkg.sv
// Shared definitions for the time-set editor: field codes, limits, FSM states and
// the 18-bit time word layout also used by the clock counter.
package time_set_editor_pkg;

    localparam int unsigned TIME_W     = 18;
    localparam int unsigned FIELD_W    = 6;
    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'b00,
        FLD_MIN  = 2'b01,
        FLD_SEC  = 2'b10,
        FLD_NONE = 2'b11
    } field_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    // {1'b0, hour[4:0], min[5:0], sec[5:0]}
    typedef struct packed {
        logic       pad;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

    // Out-of-range fields in the running time snapshot load as zero
    function automatic time_t clamp_snapshot(input time_t raw);
        time_t r;
        r.pad  = 1'b0;
        r.hour = (32'(raw.hour) > HOUR_MAX)   ? 5'd0 : raw.hour;
        r.min  = (32'(raw.min)  > MINSEC_MAX) ? 6'd0 : raw.min;
        r.sec  = (32'(raw.sec)  > MINSEC_MAX) ? 6'd0 : raw.sec;
        return r;
    endfunction

endpackage

// File: rtl/time_set_editor_if.sv
// Button inputs, running time and time-set outputs between the button front end,
// the editor and the clock counter.
interface time_set_editor_if;
    import time_set_editor_pkg::*;

    logic [TIME_W-1:0] CUR_TIME;
    logic              BTN_ENTER;
    logic              BTN_NEXT;
    logic              BTN_UP;
    logic              BTN_DOWN;
    logic              BTN_CANCEL;
    logic [TIME_W-1:0] TIME_SETDATA;
    logic              TIME_SET_FLAG;
    logic              EDIT_ACTIVE;
    logic [1:0]        EDIT_FIELD;
    logic              BLINK;

    modport master (
        output CUR_TIME, BTN_ENTER, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_CANCEL,
        input  TIME_SETDATA, TIME_SET_FLAG, EDIT_ACTIVE, EDIT_FIELD, BLINK
    );

    modport slave (
        input  CUR_TIME, BTN_ENTER, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_CANCEL,
        output TIME_SETDATA, TIME_SET_FLAG, EDIT_ACTIVE, EDIT_FIELD, BLINK
    );

endinterface

// File: rtl/time_set_editor_field_stepper.sv
// Single-field up/down step with wrap between 0 and max; up and down together hold.
module field_stepper (
    input  logic [5:0] value_i,
    input  logic [5:0] max_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [5:0] next_c
);

    always_comb begin
        next_c = value_i;
        if (up_i && !down_i) begin
            next_c = (value_i >= max_i) ? 6'd0 : value_i + 6'd1;
        end else if (down_i && !up_i) begin
            next_c = (value_i == 6'd0) ? max_i : value_i - 6'd1;
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// Button-driven time-set editor: snapshots the running time, edits h/m/s with wrap,
// and presents the result to the clock counter with a held load flag.
module time_set_editor
    import time_set_editor_pkg::*;
#(
    parameter int unsigned COMMIT_HOLD    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned BLINK_HALF     = 25_000_000
) (
    input  logic             CLK,
    input  logic             RESET,
    time_set_editor_if.slave bus
);

    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(COMMIT_HOLD + 1);
    localparam int unsigned BLK_W  = $clog2(BLINK_HALF + 1);

    state_e              state_q, state_d;
    time_t               shadow_q, shadow_d;
    logic                flag_q, flag_d;
    logic                edit_q, edit_d;
    field_e              field_q, field_d;
    logic                blink_q, blink_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BLK_W-1:0]    blk_q, blk_d;

    logic                btn_cancel, btn_enter, btn_next, btn_up, btn_down;
    logic                any_press, in_edit, timeout_hit, hold_done;
    logic [FIELD_W-1:0]  step_val, step_max, step_next;

    // Priority decode: CANCEL > ENTER > NEXT > UP/DOWN
    assign btn_cancel  = bus.BTN_CANCEL;
    assign btn_enter   = bus.BTN_ENTER & ~bus.BTN_CANCEL;
    assign btn_next    = bus.BTN_NEXT & ~bus.BTN_CANCEL & ~bus.BTN_ENTER;
    assign btn_up      = bus.BTN_UP & ~bus.BTN_CANCEL & ~bus.BTN_ENTER & ~bus.BTN_NEXT;
    assign btn_down    = bus.BTN_DOWN & ~bus.BTN_CANCEL & ~bus.BTN_ENTER & ~bus.BTN_NEXT;
    assign any_press   = |{bus.BTN_CANCEL, bus.BTN_ENTER, bus.BTN_NEXT, bus.BTN_UP, bus.BTN_DOWN};

    assign in_edit     = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);
    assign timeout_hit = !any_press && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign hold_done   = (hold_q == HOLD_W'(COMMIT_HOLD - 1));

    // Route the selected field through the single shared stepper
    always_comb begin
        step_val = shadow_q.sec;
        step_max = FIELD_W'(MINSEC_MAX);
        case (state_q)
            ST_EDIT_H: begin
                step_val = {1'b0, shadow_q.hour};
                step_max = FIELD_W'(HOUR_MAX);
            end
            ST_EDIT_M: step_val = shadow_q.min;
            default:   ;
        endcase
    end

    field_stepper u_step (
        .value_i (step_val),
        .max_i   (step_max),
        .up_i    (btn_up & in_edit),
        .down_i  (btn_down & in_edit),
        .next_c  (step_next)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            flag_q   <= 1'b0;
            edit_q   <= 1'b0;
            field_q  <= FLD_NONE;
            blink_q  <= 1'b0;
            to_q     <= '0;
            hold_q   <= '0;
            blk_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            flag_q   <= flag_d;
            edit_q   <= edit_d;
            field_q  <= field_d;
            blink_q  <= blink_d;
            to_q     <= to_d;
            hold_q   <= hold_d;
            blk_q    <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (btn_enter) state_d = ST_EDIT_H;
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (btn_cancel) begin
                    state_d = ST_IDLE;
                end else if (btn_enter) begin
                    state_d = ST_COMMIT;
                end else if (btn_next) begin
                    state_d = (state_q == ST_EDIT_H) ? ST_EDIT_M :
                              (state_q == ST_EDIT_M) ? ST_EDIT_S : ST_EDIT_H;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: if (hold_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shadow, counters and next values of the registered outputs
    always_comb begin
        shadow_d = shadow_q;
        flag_d   = 1'b0;
        edit_d   = 1'b0;
        field_d  = FLD_NONE;
        blink_d  = 1'b0;
        to_d     = '0;
        hold_d   = '0;
        blk_d    = '0;

        if (state_q == ST_IDLE && btn_enter) begin
            shadow_d = clamp_snapshot(time_t'(bus.CUR_TIME));
        end else begin
            case (state_q)
                ST_EDIT_H: shadow_d.hour = step_next[4:0];
                ST_EDIT_M: shadow_d.min  = step_next;
                ST_EDIT_S: shadow_d.sec  = step_next;
                default:   ;
            endcase
        end

        case (state_d)
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                edit_d  = 1'b1;
                field_d = (state_d == ST_EDIT_H) ? FLD_HOUR :
                          (state_d == ST_EDIT_M) ? FLD_MIN : FLD_SEC;
                to_d    = any_press ? '0 : to_q + TO_W'(1);
                if (state_d == ST_EDIT_H && state_q != ST_EDIT_H) begin
                    blink_d = 1'b1;
                    blk_d   = '0;
                end else if (blk_q == BLK_W'(BLINK_HALF - 1)) begin
                    blink_d = ~blink_q;
                    blk_d   = '0;
                end else begin
                    blink_d = blink_q;
                    blk_d   = blk_q + BLK_W'(1);
                end
            end
            ST_COMMIT: begin
                flag_d = 1'b1;
                hold_d = (state_q == ST_COMMIT) ? hold_q + HOLD_W'(1) : '0;
            end
            default: ;
        endcase
    end

    assign bus.TIME_SETDATA  = shadow_q;
    assign bus.TIME_SET_FLAG = flag_q;
    assign bus.EDIT_ACTIVE   = edit_q;
    assign bus.EDIT_FIELD    = field_q;
    assign bus.BLINK         = blink_q;

endmodule
